// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types and MEM/WB bundle widths
//
// Purpose: holds the skid-buffer occupancy enum and the field widths of the
//          MEM/WB bundle (RegWr, RegDst, MemToReg, rt, rd, Dout, Result).
// Ports:   none (package).
package pipe_pkg;

  // Occupancy of the two-entry buffer: nothing held, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int REG_IDX_W = 5;
  localparam int WORD_W    = 32;
  // RegWr + RegDst + MemToReg (3 bits) + rt + rd + Dout + Result
  localparam int MEMWB_W   = 3 + 2 * REG_IDX_W + 2 * WORD_W;

endpackage

// File: rtl/pipe_sat_cnt.sv
// rtl/pipe_sat_cnt.sv - saturating event counter
//
// Purpose: counts cycles in which inc is high; sticks at all-ones.
// Ports:   clk  - clock
//          rst  - asynchronous active-high reset, clears the count
//          inc  - count this cycle
//          cnt  - current count (W bits)
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - two-entry skid buffer pipeline stage
//
// Purpose: valid/ready pipeline register with a main and a skid entry so that
//          in_ready depends on occupancy only, never on out_ready. Entries
//          leave in FIFO order; out_data always comes from the main register.
// Macro:   PIPE_STAGE_PERF_EN adds the stall_cnt output and its counter.
// Ports:   clk       - clock, rising edge
//          rst       - asynchronous active-high reset
//          flush     - drop all held entries (wins over accept/release)
//          in_valid  - upstream offers in_data
//          in_ready  - stage can take in_data this cycle
//          in_data   - upstream payload (DATA_W bits)
//          out_valid - out_data holds a valid entry
//          out_ready - downstream takes out_data
//          out_data  - oldest held payload (DATA_W bits)
//          stall_cnt - cycles with out_valid && !out_ready (perf build only)
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W        = MEMWB_W,
  parameter bit ZERO_ON_FLUSH = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  state_t            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;

  logic accept;
  logic release_e;

  // Handshake flags are pure decodes of the registered state.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign accept    = in_valid && in_ready;
  assign release_e = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      // Flush beats any same-cycle accept or release; offered data is dropped.
      state_q <= EMPTY;
      if (ZERO_ON_FLUSH) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_q  <= in_data;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (accept && release_e) begin
            main_q <= in_data;
          end else if (release_e) begin
            state_q <= EMPTY;
            if (ZERO_ON_FLUSH) begin
              main_q <= '0;
            end
          end else if (accept) begin
            // Downstream stalled: park the newer entry behind main.
            skid_q  <= in_data;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (release_e) begin
            main_q  <= skid_q;
            state_q <= ONE;
            if (ZERO_ON_FLUSH) begin
              skid_q <= '0;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counts stalls regardless of flush; only rst clears it.
  pipe_sat_cnt #(
    .W(32)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(out_valid && !out_ready),
    .cnt(stall_cnt)
  );
`else
  // Default build carries no performance counter.
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - self-checking bench for pipe_stage_buf
module tb_pipe_stage_buf;

  localparam int DW = 77;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: an ordered list of held payloads, at most two long.
  logic [DW-1:0] q[$];
  longint        stall_m = 0;

  pipe_stage_buf #(
    .DATA_W(DW),
    .ZERO_ON_FLUSH(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    logic [DW-1:0] e;
    e = (q.size() > 0) ? q[0] : '0;
    chk("in_ready", {127'd0, in_ready}, {127'd0, (q.size() < 2)});
    chk("out_valid", {127'd0, out_valid}, {127'd0, (q.size() > 0)});
    chk("out_data", {51'd0, out_data}, {51'd0, e});
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", {96'd0, stall_cnt}, {96'd0, stall_m[31:0]});
`endif
  endtask

  // One clock: drive inputs, advance the model with pre-edge occupancy, check.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bit acc;
    bit rel;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && (q.size() < 2);
    rel = r && (q.size() > 0);
    @(posedge clk);
    if (q.size() > 0 && !r) stall_m++;
    if (f) begin
      q.delete();
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(d);
    end
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    stall_m = 0;
    @(posedge clk);
    #1;
    chk_all();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    #3;
    chk("reset_in_ready", {127'd0, in_ready}, 128'd1);
    chk("reset_out_valid", {127'd0, out_valid}, 128'd0);
    chk("reset_out_data", {51'd0, out_data}, 128'd0);
    do_reset();

    // Stream: one per cycle, visible one cycle after accept.
    cycle(1'b1, 77'h1, 1'b1, 1'b0);
    chk("stream_d1", {51'd0, out_data}, 128'h1);
    cycle(1'b1, 77'h2, 1'b1, 1'b0);
    chk("stream_d2", {51'd0, out_data}, 128'h2);
    cycle(1'b1, 77'h3, 1'b1, 1'b0);
    chk("stream_d3", {51'd0, out_data}, 128'h3);
    chk("stream_rdy", {127'd0, in_ready}, 128'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("stream_empty", {127'd0, out_valid}, 128'd0);

    // Backpressure: fill with A/B, hold, then drain in order.
    cycle(1'b1, 77'hA, 1'b0, 1'b0);
    cycle(1'b1, 77'hB, 1'b0, 1'b0);
    chk("bp_full_rdy", {127'd0, in_ready}, 128'd0);
    chk("bp_hold_a", {51'd0, out_data}, 128'hA);
    cycle(1'b1, 77'hE, 1'b0, 1'b0);
    chk("bp_still_a", {51'd0, out_data}, 128'hA);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_then_b", {51'd0, out_data}, 128'hB);
    chk("bp_rdy_back", {127'd0, in_ready}, 128'd1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", {51'd0, out_data}, 128'h0);

    // Flush wins over a same-cycle offer.
    cycle(1'b1, 77'hA, 1'b0, 1'b0);
    cycle(1'b1, 77'hB, 1'b0, 1'b0);
    cycle(1'b1, 77'hC, 1'b1, 1'b1);
    chk("flush_valid", {127'd0, out_valid}, 128'd0);
    chk("flush_data", {51'd0, out_data}, 128'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("flush_no_c", {127'd0, out_valid}, 128'd0);

    // Accept and release together in ONE.
    cycle(1'b1, 77'h4, 1'b0, 1'b0);
    cycle(1'b1, 77'h5, 1'b1, 1'b0);
    chk("simul_data", {51'd0, out_data}, 128'h5);
    chk("simul_rdy", {127'd0, in_ready}, 128'd1);

    // Asynchronous reset mid-cycle while in ONE.
    #2;
    rst = 1'b1;
    q.delete();
    stall_m = 0;
    #1;
    chk("arst_valid", {127'd0, out_valid}, 128'd0);
    chk("arst_data", {51'd0, out_data}, 128'd0);
    chk("arst_rdy", {127'd0, in_ready}, 128'd1);
    #1;
    rst = 1'b0;
    cycle(1'b1, 77'h7, 1'b1, 1'b0);
    chk("first_accept", {51'd0, out_data}, 128'h7);
    cycle(1'b0, '0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    cycle(1'b1, 77'h9, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    chk("perf_five", {96'd0, stall_cnt}, 128'd5);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("perf_keep", {96'd0, stall_cnt}, 128'd5);
`endif

    // Random traffic against the queue model.
    for (int i = 0; i < 500; i++) begin
      rd = {$urandom(), $urandom(), $urandom()};
      cycle(($urandom_range(0, 3) != 0), rd, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
